imm_gen_pipe: RTL and testbench

Parametrised, pipelined successor to the decode-stage immediate generator. Extracts and extends I/U/S/B/J immediates to XLEN bits, with an optional CSR zimm type. Sits between fetch/decode and the execute stage with valid/ready handshakes on both sides. A two-entry skid buffer gives one-cycle latency, full throughput and registered ready; a tag (e.g. PC) travels with each immediate.

---
 rtl/imm_gen_pkg.sv | 14 +
 rtl/imm_gen_core.sv | 37 +++
 rtl/imm_gen_pipe.sv | 108 ++++++++++
 tb/tb_imm_gen_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared constants for the pipelined immediate generator.
package imm_gen_pkg;

   localparam int unsigned SEL_W = 3;

   // Immediate type select codes; 0 and 7 (and 6 without zimm) fall back to I
   localparam logic [SEL_W-1:0] SEL_I = 3'd1;
   localparam logic [SEL_W-1:0] SEL_U = 3'd2;
   localparam logic [SEL_W-1:0] SEL_S = 3'd3;
   localparam logic [SEL_W-1:0] SEL_B = 3'd4;
   localparam logic [SEL_W-1:0] SEL_J = 3'd5;
   localparam logic [SEL_W-1:0] SEL_Z = 3'd6;

endpackage

// File: rtl/imm_gen_core.sv
// Combinational immediate extraction/extension to XLEN bits.
// IMM_GEN_PIPE_ZIMM_EN adds the zero-extended CSR immediate on select 6.
module imm_gen_core
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]      i_instruction,
   input  logic [SEL_W-1:0] i_sel,
   output logic [XLEN-1:0]  o_imm_c
);

   logic [31:0] imm32;
   logic        unused_opcode;

   // Opcode bits never contribute to any immediate
   assign unused_opcode = ^i_instruction[6:0];

   // Every immediate fits in 32 bits sign-extended, so widen once at the end
   always_comb begin
      imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
      case (i_sel)
         SEL_U: imm32 = {i_instruction[31:12], 12'h000};
         SEL_S: imm32 = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
         SEL_B: imm32 = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                         i_instruction[30:25], i_instruction[11:8], 1'b0};
         SEL_J: imm32 = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                         i_instruction[20], i_instruction[30:21], 1'b0};
`ifdef IMM_GEN_PIPE_ZIMM_EN
         SEL_Z: imm32 = {27'd0, i_instruction[19:15]};
`endif
         default: imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
      endcase
      o_imm_c = XLEN'($signed(imm32));
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one-cycle latency, two-entry skid buffer,
// registered ready, tag carried alongside each decoded immediate.
// Build option: IMM_GEN_PIPE_ZIMM_EN enables the CSR zimm type (select 6).
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [31:0]        i_instruction,
   input  logic [SEL_W-1:0]   i_sel,
   input  logic [TAG_W-1:0]   i_tag,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [XLEN-1:0]    o_dataout,
   output logic [TAG_W-1:0]   o_tag
);

   logic [XLEN-1:0]  imm_c;
   logic             accept_c;
   logic             m_free_c;

   logic             m_valid_q, m_valid_d;
   logic [XLEN-1:0]  m_data_q,  m_data_d;
   logic [TAG_W-1:0] m_tag_q,   m_tag_d;
   logic             s_valid_q, s_valid_d;
   logic [XLEN-1:0]  s_data_q,  s_data_d;
   logic [TAG_W-1:0] s_tag_q,   s_tag_d;
   logic             ready_q,   ready_d;

   imm_gen_core #(.XLEN(XLEN)) u_core (
      .i_instruction (i_instruction),
      .i_sel         (i_sel),
      .o_imm_c       (imm_c)
   );

   assign accept_c = i_valid && ready_q;
   assign m_free_c = !m_valid_q || i_ready;

   // Skid buffer next state: skid drains into main first, stalled inputs park in skid
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_tag_d   = m_tag_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_tag_d   = s_tag_q;

      if (m_free_c) begin
         if (s_valid_q) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            m_tag_d   = s_tag_q;
            s_valid_d = 1'b0;
         end else if (accept_c) begin
            m_valid_d = 1'b1;
            m_data_d  = imm_c;
            m_tag_d   = i_tag;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (accept_c) begin
         s_valid_d = 1'b1;
         s_data_d  = imm_c;
         s_tag_d   = i_tag;
      end

      if (i_flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end

      // Ready is registered: it reflects whether skid will be empty next cycle
      ready_d = !s_valid_d;
   end

   // State registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_tag_q   <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_tag_q   <= '0;
         ready_q   <= 1'b1;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_tag_q   <= m_tag_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_tag_q   <= s_tag_d;
         ready_q   <= ready_d;
      end
   end

   assign o_valid   = m_valid_q;
   assign o_dataout = m_data_q;
   assign o_tag     = m_tag_q;
   assign o_ready   = ready_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_pipe;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_flush = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic [31:0] i_instruction = 32'd0;
   logic [2:0]  i_sel = 3'd0;
   logic [31:0] i_tag = 32'd0;

   logic        o_valid32, o_ready32, o_valid64, o_ready64;
   logic [31:0] o_data32, o_tag32, o_tag64;
   logic [63:0] o_data64;

   typedef struct {
      logic [63:0] imm;
      logic [31:0] tag;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   always #5 i_clk = ~i_clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready32), .i_instruction(i_instruction), .i_sel(i_sel),
      .i_tag(i_tag), .o_valid(o_valid32), .i_ready(i_ready),
      .o_dataout(o_data32), .o_tag(o_tag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready64), .i_instruction(i_instruction), .i_sel(i_sel),
      .i_tag(i_tag), .o_valid(o_valid64), .i_ready(i_ready),
      .o_dataout(o_data64), .o_tag(o_tag64)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference immediate at 64 bits; the 32-bit result is its low half
   function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] sel);
      logic [63:0] r;
      case (sel)
         3'd2: r = {{32{ins[31]}}, ins[31:12], 12'h000};
         3'd3: r = {{52{ins[31]}}, ins[31:25], ins[11:7]};
         3'd4: r = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         3'd5: r = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef IMM_GEN_PIPE_ZIMM_EN
         3'd6: r = {59'd0, ins[19:15]};
`endif
         default: r = {{52{ins[31]}}, ins[31:20]};
      endcase
      return r;
   endfunction

   // Monitor: compare output against queue head every cycle, record accepts
   always @(negedge i_clk) begin
      if (i_rst || i_flush) begin
         q.delete();
      end else begin
         check_eq("valid32", 64'(o_valid32), 64'(q.size() != 0));
         check_eq("valid64", 64'(o_valid64), 64'(q.size() != 0));
         if (q.size() != 0) begin
            check_eq("data32", 64'(o_data32), 64'(q[0].imm[31:0]));
            check_eq("tag32",  64'(o_tag32),  64'(q[0].tag));
            check_eq("data64", o_data64,      q[0].imm);
            check_eq("tag64",  64'(o_tag64),  64'(q[0].tag));
            if (i_ready) void'(q.pop_front());
         end
         if (i_valid && o_ready32) begin
            q.push_back('{imm: model_imm(i_instruction, i_sel), tag: i_tag});
         end
      end
   end

   task automatic push(input logic [31:0] ins, input logic [2:0] sel, input logic [31:0] tag);
      logic rdy;
      bit   done;
      done = 1'b0;
      i_valid = 1'b1;
      i_instruction = ins;
      i_sel = sel;
      i_tag = tag;
      for (int k = 0; k < 20 && !done; k++) begin
         rdy = o_ready32;
         @(posedge i_clk); #1;
         done = rdy;
      end
      check_eq("push_accept", 64'(done), 64'd1);
      i_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 20 && q.size() != 0; k++) begin
         @(posedge i_clk); #1;
      end
      check_eq("drain", 64'(q.size()), 64'd0);
   endtask

   task automatic check_idle_state(input string tag);
      check_eq({tag, "_valid32"}, 64'(o_valid32), 64'd0);
      check_eq({tag, "_ready32"}, 64'(o_ready32), 64'd1);
      check_eq({tag, "_valid64"}, 64'(o_valid64), 64'd0);
      check_eq({tag, "_ready64"}, 64'(o_ready64), 64'd1);
   endtask

   logic [31:0] tbl_ins [10] = '{32'hFFF00093, 32'h12345037, 32'hFE000EE3, 32'h0080006F,
                                 32'h800000B7, 32'h7FF00093, 32'hFFF00093, 32'hFFF00093,
                                 32'h000FD073, 32'hFE112C23};
   logic [2:0]  tbl_sel [10] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd3};

   initial begin
      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      check_idle_state("rst");
      check_eq("rst_data32", 64'(o_data32), 64'd0);
      check_eq("rst_tag32",  64'(o_tag32),  64'd0);
      check_eq("rst_data64", o_data64,      64'd0);
      i_rst = 1'b0;

      // Back-to-back stream with continuous ready
      i_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(tbl_ins[i], tbl_sel[i], 32'h100 + 32'(i));
         check_eq("thru_ready", 64'(o_ready32), 64'd1);
         if (i == 0) begin
            check_eq("lat_valid", 64'(o_valid32), 64'd1);
            check_eq("lat_tag",   64'(o_tag32),   64'h100);
         end
      end
      wait_drain();

      // Backpressure: fill main and skid, third entry held upstream
      i_ready = 1'b0;
      push(32'hFFF00093, 3'd1, 32'd1);
      push(32'h12345037, 3'd2, 32'd2);
      check_eq("bp_ready_low", 64'(o_ready32), 64'd0);
      i_valid = 1'b1;
      i_instruction = 32'hFE000EE3;
      i_sel = 3'd4;
      i_tag = 32'd3;
      repeat (3) @(posedge i_clk);
      #1;
      check_eq("bp_ready32", 64'(o_ready32), 64'd0);
      check_eq("bp_ready64", 64'(o_ready64), 64'd0);
      check_eq("bp_valid",   64'(o_valid32), 64'd1);
      check_eq("bp_tag",     64'(o_tag32),   64'd1);
      i_ready = 1'b1;
      push(32'hFE000EE3, 3'd4, 32'd3);
      wait_drain();

      // Flush with both entries full and an input offered
      i_ready = 1'b0;
      push(32'h0080006F, 3'd5, 32'h20);
      push(32'h800000B7, 3'd2, 32'h21);
      i_valid = 1'b1;
      i_instruction = 32'h7FF00093;
      i_sel = 3'd1;
      i_tag = 32'd9;
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      i_valid = 1'b0;
      check_idle_state("flush");
      i_ready = 1'b1;
      repeat (4) @(posedge i_clk);
      #1;
      check_eq("flush_empty", 64'(q.size()), 64'd0);

      // Reset in the middle of a stall
      i_ready = 1'b0;
      push(32'hFFF00093, 3'd1, 32'h30);
      push(32'h12345037, 3'd2, 32'h31);
      i_valid = 1'b1;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      check_idle_state("mid_rst");
      check_eq("mid_rst_data32", 64'(o_data32), 64'd0);
      check_eq("mid_rst_tag32",  64'(o_tag32),  64'd0);
      check_eq("mid_rst_data64", o_data64,      64'd0);
      i_rst = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;

      // Pipe still works after reset
      push(32'h7FF00093, 3'd1, 32'h40);
      wait_drain();
      repeat (2) @(posedge i_clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
